// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants and helpers for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Width needed to count 0..clks-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the UART transmitter.
interface fifo_uart_tx_if;

    logic       empty;
    logic       rd_en;
    logic [7:0] dout;

    // master: the consumer issuing pops; slave: the FIFO answering them.
    modport master (output rd_en, input empty, input dout);
    modport slave  (input rd_en, output empty, output dout);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: pulses period_done on the last cycle of each bit period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned CNT_WIDTH    = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic period_done
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Gated by clear so a held-off timer never reports a finished period.
    assign period_done = ~clear & (cnt_q == LAST);

    // Free-running within a period, wraps to 0 at the period boundary or on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || period_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO read port and serialises them as 8N1 UART, LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 125_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned BYTES_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    fifo_uart_tx_if.master         fifo,
    output logic                   serial_out,
    output logic                   busy,
    output logic [BYTES_WIDTH-1:0] bytes_sent
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_WIDTH    = cnt_width(CLKS_PER_BIT);
    localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_idx_q;
    logic                   serial_q;
    logic [BYTES_WIDTH-1:0] bytes_q;
    logic                   period_done;
    logic                   timer_clear;

    // Counter is held at zero until the start bit begins.
    assign timer_clear = (state_q == StIdle) || (state_q == StLoad);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (timer_clear),
        .period_done (period_done)
    );

    // Single-cycle pop from IDLE; rst_n term keeps the pop quiet while reset is held.
    assign fifo.rd_en = rst_n & (state_q == StIdle) & enable & ~fifo.empty;

    assign serial_out = serial_q;
    assign busy       = (state_q != StIdle);
    assign bytes_sent = bytes_q;

    // Frame sequencer with registered line output and byte statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            bytes_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fifo.rd_en) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    // FIFO data is valid the cycle after the pop.
                    shift_q  <= fifo.dout;
                    serial_q <= 1'b0;
                    state_q  <= StStart;
                end
                StStart: begin
                    if (period_done) begin
                        bit_idx_q <= '0;
                        serial_q  <= shift_q[0];
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (period_done) begin
                        if (bit_idx_q == LAST_BIT) begin
                            serial_q <= 1'b1;
                            state_q  <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= shift_q[bit_idx_q + 3'd1];
                        end
                    end
                end
                StStop: begin
                    if (period_done) begin
                        bytes_q <= bytes_q + 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + randomized bench for fifo_uart_tx with a FIFO model and a line-trace reference.
module tb_fifo_uart_tx;

    localparam int CPB    = 10;
    localparam int FRAME  = 10 * CPB;
    localparam int LOGN   = 8192;
    localparam int BUDGET = 400;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       serial_out;
    logic       busy;
    logic [3:0] bytes_sent;

    int total = 0;
    int bad   = 0;

    fifo_uart_tx_if fif ();

    fifo_uart_tx #(
        .CLOCK_FREQ  (1000),
        .BAUD_RATE   (100),
        .BYTES_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo       (fif),
        .serial_out (serial_out),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    // FIFO model: 1-cycle registered read data, honours every pop while non-empty.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fif.empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fif.rd_en && !fif.empty) begin
            fif.dout <= mem[rd_ptr[5:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Per-cycle trace of the line, busy and pop strobe, indexed by cycle number.
    int cyc  = 0;
    int viol = 0;
    bit line_log [0:LOGN-1];
    bit busy_log [0:LOGN-1];
    bit rd_log   [0:LOGN-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            line_log[cyc] <= serial_out;
            busy_log[cyc] <= busy;
            rd_log[cyc]   <= fif.rd_en;
        end
        if (fif.rd_en && (fif.empty || busy)) viol <= viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Returns just after a posedge (drive phase) with all log entries below n valid.
    task automatic sync_to(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < n);
    endtask

    task automatic find_rd(input int from, output int at, input string tag);
        at = -1;
        for (int i = from; i < from + BUDGET; i++) begin
            if (cyc <= i) sync_to(i + 1);
            if (rd_log[i]) begin
                at = i;
                return;
            end
        end
        total++;
        bad++;
        $error("FAIL %s_rd_timeout observed=none required=pop within %0d cycles", tag, BUDGET);
    endtask

    function automatic int count_log(input int sel, input int a, input int b, input bit val);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            if (sel == 0 && line_log[i] == val) n++;
            if (sel == 1 && busy_log[i] == val) n++;
            if (sel == 2 && rd_log[i] == val) n++;
        end
        return n;
    endfunction

    // Expected frame from the byte value: start 0, data LSB first, stop 1, CPB cycles each.
    task automatic check_frame(input int rd, input logic [7:0] b, input string tag);
        int   m;
        logic e;
        if (rd < 0) return;
        sync_to(rd + 3 + FRAME);
        check({tag, "_idle_before_start"}, int'(line_log[rd + 1]), 1);
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k - 1];
            m = 0;
            for (int j = 0; j < CPB; j++) begin
                if (line_log[rd + 2 + k * CPB + j] == e) m++;
            end
            check($sformatf("%s_bit%0d", tag, k), m, CPB);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check({tag, "_rst_line"}, int'(serial_out), 1);
        check({tag, "_rst_busy"}, int'(busy), 0);
        check({tag, "_rst_bytes"}, int'(bytes_sent), 0);
        check({tag, "_rst_rd"}, int'(fif.rd_en), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int r1;
        int r2;
        int c0;
        int g;
        int idx;
        int prev;
        logic [7:0] rb [0:16];

        // 1: single byte 0xA5
        do_reset("t1");
        enable = 1'b1;
        push(8'hA5);
        find_rd(cyc, r1, "t1");
        check_frame(r1, 8'hA5, "t1");
        if (r1 >= 0) begin
            sync_to(r1 + 112);
            check("t1_rd_pulses", count_log(2, r1, r1 + 111, 1'b1), 1);
            check("t1_busy_cycles", count_log(1, r1, r1 + 111, 1'b1), 101);
            check("t1_bytes", int'(bytes_sent), 1);
        end

        // 2: back-to-back 0x00, 0xFF
        do_reset("t2");
        enable = 1'b1;
        push(8'h00);
        push(8'hFF);
        find_rd(cyc, r1, "t2a");
        find_rd(r1 + 1, r2, "t2b");
        if (r1 >= 0 && r2 >= 0) begin
            check("t2_rd_spacing", r2 - r1, FRAME + 2);
            check_frame(r1, 8'h00, "t2a");
            check_frame(r2, 8'hFF, "t2b");
            g   = 0;
            idx = r1 + 2 + 9 * CPB;
            while (idx < LOGN && line_log[idx] == 1'b1 && g < 100) begin
                g++;
                idx++;
            end
            check("t2_gap", g, CPB + 2);
            sync_to(r2 + 112);
            check("t2_rd_pulses", count_log(2, r1, r2 + 111, 1'b1), 2);
            check("t2_bytes", int'(bytes_sent), 2);
        end

        // 3: empty FIFO for 500 cycles
        do_reset("t3");
        enable = 1'b1;
        c0 = cyc;
        sync_to(c0 + 501);
        check("t3_rd", count_log(2, c0, c0 + 499, 1'b1), 0);
        check("t3_busy", count_log(1, c0, c0 + 499, 1'b1), 0);
        check("t3_line_low", count_log(0, c0, c0 + 499, 1'b0), 0);

        // 4: enable dropped mid-byte
        do_reset("t4");
        enable = 1'b1;
        push(8'h3C);
        find_rd(cyc, r1, "t4a");
        if (r1 >= 0) begin
            sync_to(r1 + 2 + 3 * CPB + 5);
            enable = 1'b0;
            push(8'h11);
            sync_to(r1 + FRAME + 32);
            check("t4_no_rd_disabled", count_log(2, r1 + 1, cyc - 1, 1'b1), 0);
            check_frame(r1, 8'h3C, "t4a");
            check("t4_bytes1", int'(bytes_sent), 1);
            @(posedge clk);
            #1;
            enable = 1'b1;
            c0 = cyc;
            find_rd(c0, r2, "t4b");
            check("t4_rd_on_enable", r2, c0);
            check_frame(r2, 8'h11, "t4b");
            if (r2 >= 0) begin
                sync_to(r2 + 104);
                check("t4_bytes2", int'(bytes_sent), 2);
            end
        end

        // 5: reset mid-DATA, then restart from a non-empty FIFO
        do_reset("t5");
        enable = 1'b1;
        push(8'h5A);
        find_rd(cyc, r1, "t5a");
        if (r1 >= 0) begin
            sync_to(r1 + 2 + 4 * CPB + 3);
            push(8'h96);
            rst_n = 1'b0;
            #1;
            check("t5_mid_line", int'(serial_out), 1);
            check("t5_mid_busy", int'(busy), 0);
            check("t5_mid_bytes", int'(bytes_sent), 0);
            check("t5_mid_rd", int'(fif.rd_en), 0);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            c0 = cyc;
            find_rd(c0, r2, "t5b");
            check("t5_rd_first_idle", r2, c0);
            check_frame(r2, 8'h96, "t5b");
            if (r2 >= 0) begin
                sync_to(r2 + 104);
                check("t5_bytes", int'(bytes_sent), 1);
            end
        end

        // 6: 17 random bytes back-to-back, counter wraps
        do_reset("t6");
        enable = 1'b1;
        for (int k = 0; k < 17; k++) begin
            rb[k] = 8'($urandom_range(0, 255));
            push(rb[k]);
        end
        prev = -1;
        for (int k = 0; k < 17; k++) begin
            find_rd((prev < 0) ? cyc : prev + 1, r1, $sformatf("t6_%0d", k));
            if (r1 < 0) break;
            if (k > 0) check($sformatf("t6_spacing%0d", k), r1 - prev, FRAME + 2);
            check_frame(r1, rb[k], $sformatf("t6_%0d", k));
            prev = r1;
        end
        if (prev >= 0) begin
            sync_to(prev + 104);
            check("t6_bytes_wrap", int'(bytes_sent), 1);
        end

        check("rd_protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
